// File: rtl/jt49_mave_mc.sv
// Multichannel moving-average filter, window 2^wsel, one shared adder stepping channels in CH cycles.
// Output CH+1 clocks after cen; cen while busy is dropped and flagged on ovr.
module jt49_mave_mc #(
   parameter int DW     = 8,
   parameter int CH     = 3,
   parameter int MAXLOG = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cen,
   input  logic [CH*DW-1:0] din,
   input  logic [3:0]       wsel,
   output logic [CH*DW-1:0] dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             ovr
);

   localparam int SW    = DW + MAXLOG;
   localparam int AW    = MAXLOG;
   localparam int DEPTH = 1 << MAXLOG;
   localparam int KW    = (CH > 1) ? $clog2(CH) : 1;
   localparam logic [3:0]    MAXW  = 4'(MAXLOG);
   localparam logic [KW-1:0] KLAST = KW'(CH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FLUSH} state_t;

   state_t               state_q, state_d;
   logic [KW-1:0]        k_q;
   logic [AW-1:0]        wptr_q;
   logic [AW-1:0]        fcnt_q;
   logic [3:0]           win_q;
   logic [CH*DW-1:0]     x_q;
   logic                 done_q;
   logic [CH*DW-1:0]     dout_q;
   logic                 valid_q;
   logic signed [SW-1:0] sum_q [CH];
   logic [DW-1:0]        hist  [CH][DEPTH];

   logic [3:0]           wsel_c;
   logic                 flush_go;
   logic                 last;
   logic [AW-1:0]        raddr;
   logic [DW-1:0]        rd [CH];
   logic signed [SW-1:0] x_ext, old_ext, sum_nx;
   logic [CH*DW-1:0]     avg;

   always_comb begin
      wsel_c   = (wsel > MAXW) ? MAXW : wsel;
      flush_go = (state_q == IDLE) && (wsel_c != win_q);
      last     = (k_q == KLAST);
      state_d  = state_q;
      case (state_q)
         IDLE:    if (flush_go) state_d = FLUSH;
                  else if (cen) state_d = CALC;
         CALC:    if (last) state_d = IDLE;
         FLUSH:   if (&fcnt_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Full-depth window reads the slot being written; async read returns its old value.
   always_comb begin
      raddr = (win_q == MAXW) ? wptr_q : wptr_q - (AW'(1) << win_q);
      for (int c = 0; c < CH; c++) rd[c] = hist[c][raddr];
      x_ext   = SW'($signed(x_q[k_q*DW +: DW]));
      old_ext = SW'($signed(rd[k_q]));
      sum_nx  = sum_q[k_q] + x_ext - old_ext;
      for (int c = 0; c < CH; c++) avg[c*DW +: DW] = DW'(sum_q[c] >>> win_q);
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < CH; c++) begin
         if (state_q == FLUSH)
            hist[c][fcnt_q] <= '0;
         else if (state_q == CALC && k_q == KW'(c))
            hist[c][wptr_q] <= x_q[c*DW +: DW];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FLUSH;
         k_q     <= '0;
         wptr_q  <= '0;
         fcnt_q  <= '0;
         win_q   <= wsel_c;
         done_q  <= 1'b0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         for (int c = 0; c < CH; c++) sum_q[c] <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (flush_go) begin
                  fcnt_q <= '0;
                  wptr_q <= '0;
                  win_q  <= wsel_c;
                  dout_q <= '0;
                  for (int c = 0; c < CH; c++) sum_q[c] <= '0;
               end else begin
                  if (done_q) begin
                     dout_q  <= avg;
                     valid_q <= 1'b1;
                  end
                  if (cen) begin
                     x_q <= din;
                     k_q <= '0;
                  end
               end
            end
            CALC: begin
               sum_q[k_q] <= sum_nx;
               if (last) begin
                  wptr_q <= wptr_q + AW'(1);
                  done_q <= 1'b1;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            FLUSH:   fcnt_q <= fcnt_q + AW'(1);
            default: ;
         endcase
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign busy       = rst | (state_q != IDLE);
   assign ovr        = ~rst & cen & ((state_q != IDLE) | flush_go);

endmodule

// File: tb/tb_jt49_mave_mc.sv
// Directed bench for jt49_mave_mc with DW=8, CH=3, MAXLOG=4.
module tb_jt49_mave_mc;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cen = 1'b0;
   logic [23:0] din = '0;
   logic [3:0]  wsel = 4'd2;
   logic [23:0] dout;
   logic        dout_valid, busy, ovr;
   int total = 0;
   int bad   = 0;

   jt49_mave_mc #(.DW(8), .CH(3), .MAXLOG(4)) dut (
      .clk(clk), .rst(rst), .cen(cen), .din(din), .wsel(wsel),
      .dout(dout), .dout_valid(dout_valid), .busy(busy), .ovr(ovr)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [31:0] dch(input int k);
      logic signed [7:0] v;
      v = dout[k*8 +: 8];
      return 32'(v);
   endfunction

   task automatic do_cen(input logic signed [7:0] c0, input logic signed [7:0] c1,
                         input logic signed [7:0] c2, input string tag);
      int n = 0;
      din = {c2, c1, c0};
      cen = 1'b1;
      tick;
      cen = 1'b0;
      while (!dout_valid && n < 20) begin
         tick;
         n++;
      end
      chk({tag, "_lat"}, n, 4);
   endtask

   // Counts clocks while busy; optionally fires a cen mid-flush.
   task automatic wait_flush(input string tag, input bit poke);
      int n = 0;
      int v = 0;
      int nz = 0;
      while (busy && n < 100) begin
         tick;
         n++;
         if (dout_valid) v++;
         if (busy && dout !== 24'd0) nz++;
         if (poke && n == 2) begin
            din = {8'd0, 8'd0, 8'd99};
            cen = 1'b1;
            #1;
            chk({tag, "_ovr"}, ovr, 1);
         end else begin
            cen = 1'b0;
         end
      end
      chk({tag, "_len"}, n, 16);
      chk({tag, "_vld"}, v, 0);
      chk({tag, "_dz"}, nz, 0);
   endtask

   int e0 [5] = '{10, 20, 30, 40, 40};
   int e1 [5] = '{-32, -64, -96, -128, -128};

   initial begin
      int nv;
      logic signed [31:0] got;

      // reset, with cen held to prove ovr stays quiet
      rst = 1'b1;
      cen = 1'b1;
      tick;
      tick;
      chk("rst_busy", busy, 1);
      chk("rst_dout", dout, 0);
      chk("rst_vld", dout_valid, 0);
      chk("rst_ovr", ovr, 0);
      cen = 1'b0;
      rst = 1'b0;
      wait_flush("init", 1'b0);

      // window 4: ch0 = 40, ch1 = -128, ch2 = 0
      for (int i = 0; i < 5; i++) begin
         do_cen(8'sd40, -8'sd128, 8'sd0, $sformatf("a%0d", i));
         chk($sformatf("a%0d_ch0", i), dch(0), e0[i]);
         chk($sformatf("a%0d_ch1", i), dch(1), e1[i]);
         chk($sformatf("a%0d_ch2", i), dch(2), 0);
         tick;
         chk($sformatf("a%0d_pulse", i), dout_valid, 0);
      end

      // second cen one clock after the first is dropped
      din = '0;
      cen = 1'b1;
      tick;
      din = {8'd0, 8'd0, 8'd100};
      #1;
      chk("b_ovr", ovr, 1);
      chk("b_busy", busy, 1);
      tick;
      cen = 1'b0;
      #1;
      chk("b_ovr_off", ovr, 0);
      nv = 0;
      got = 'x;
      for (int i = 0; i < 10; i++) begin
         tick;
         if (dout_valid) begin
            nv++;
            got = dch(0);
         end
      end
      chk("b_nvld", nv, 1);
      chk("b_ch0", got, 30);
      do_cen(8'sd0, 8'sd0, 8'sd0, "b2");
      chk("b2_ch0", dch(0), 20);
      chk("b2_ch1", dch(1), -64);

      // window change 4 -> 8 flushes; cen during flush is refused
      wsel = 4'd3;
      tick;
      wait_flush("w3", 1'b1);
      do_cen(8'sd40, -8'sd128, 8'sd0, "c");
      chk("c_ch0", dch(0), 5);
      chk("c_ch1", dch(1), -16);

      // full-depth window, then clamp of an out-of-range wsel
      wsel = 4'd4;
      tick;
      wait_flush("w4", 1'b0);
      wsel = 4'd15;
      tick;
      chk("clamp_busy", busy, 0);
      for (int n = 1; n <= 16; n++) begin
         do_cen(8'sd1, 8'sd0, 8'sd0, $sformatf("up%0d", n));
         chk($sformatf("up%0d_ch0", n), dch(0), (n == 16) ? 1 : 0);
      end
      for (int j = 1; j <= 16; j++) begin
         do_cen(-8'sd1, 8'sd0, 8'sd0, $sformatf("dn%0d", j));
         chk($sformatf("dn%0d_ch0", j), dch(0), (j <= 8) ? 0 : -1);
      end

      // reset mid-CALC, with a deferred wsel change pending
      din = {8'd0, 8'd0, 8'd5};
      cen = 1'b1;
      tick;
      cen = 1'b0;
      wsel = 4'd2;
      tick;
      chk("e_busy_calc", busy, 1);
      rst = 1'b1;
      tick;
      chk("e_vld", dout_valid, 0);
      chk("e_dout", dout, 0);
      chk("e_busy", busy, 1);
      rst = 1'b0;
      wait_flush("e_fl", 1'b0);
      do_cen(8'sd8, 8'sd0, 8'sd0, "e2");
      chk("e2_ch0", dch(0), 2);
      chk("e2_ch1", dch(1), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
